axi4lite_slave_regs: RTL and testbench
======================================

Name: axi4lite_slave_regs

Overview:
- AXI4-Lite responder (slave) holding a small register file.
- It is the far end of the initiator driven by the tt_um_axi4lite_top user ports: it accepts AW/W/AR transactions and returns B/R responses.
- It exposes all register contents in parallel so the top can drive them to output pins.
- It handles independent AW/W arrival, response backpressure and out-of-range addresses.

Parameters:
- ADDR_WIDTH, 2: width of awaddr/araddr. The address is a word index, not a byte address.
- DATA_WIDTH, 8: register and data-bus width. Must be a multiple of 8.
- NUM_REGS, 4: number of implemented registers. Must satisfy 1 <= NUM_REGS <= 2^ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- awaddr  input  ADDR_WIDTH  write address
- awvalid  input  1  write address valid
- awready  output  1  write address ready
- wdata  input  DATA_WIDTH  write data
- wstrb  input  DATA_WIDTH/8  byte-lane write enables
- wvalid  input  1  write data valid
- wready  output  1  write data ready
- bresp  output  2  write response: 2'b00 OKAY, 2'b10 SLVERR
- bvalid  output  1  write response valid
- bready  input  1  write response ready
- araddr  input  ADDR_WIDTH  read address
- arvalid  input  1  read address valid
- arready  output  1  read address ready
- rdata  output  DATA_WIDTH  read data
- rresp  output  2  read response: 2'b00 OKAY, 2'b10 SLVERR
- rvalid  output  1  read data valid
- rready  input  1  read data ready
- regs_flat  output  NUM_REGS*DATA_WIDTH  register contents; reg i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Interface: one clock (clk). Reset is synchronous, active-high (rst).
- Reset values: all registers 0; awready=1, wready=1, arready=1; bvalid=0, rvalid=0; bresp=00, rresp=00, rdata=0.
- Reset mid-operation aborts any pending transaction. No response is issued for it.
- Handshake rule: a transfer occurs on a rising edge where valid && ready. Once asserted, bvalid/rvalid hold, and bresp/rresp/rdata stay stable, until the matching ready is sampled high.
- Write FSM states: W_IDLE, W_COLLECT, W_RESP.
  - W_IDLE: awready=1, wready=1.
    - AW and W both handshake on the same edge → commit, go to W_RESP.
    - Only one handshakes → latch it, drop its ready, go to W_COLLECT.
  - W_COLLECT: only the missing channel's ready is high. Its handshake → commit, go to W_RESP.
  - W_RESP: awready=0, wready=0, bvalid=1. Edge with bready=1 → bvalid=0, both readys return to 1, go to W_IDLE.
- Commit:
  - Occurs on the edge completing the later handshake, using the latched or live address/data.
  - If address < NUM_REGS: each byte lane k with wstrb[k]=1 is updated; other lanes are unchanged; bresp=00.
  - Otherwise: no register changes; bresp=10.
  - bvalid is high from the cycle after commit. Minimum write latency: 1 cycle from commit edge to bvalid.
- Read FSM states: R_IDLE, R_RESP.
  - R_IDLE: arready=1. AR handshake → capture data and go to R_RESP.
    - rdata = reg[araddr], sampled from pre-edge register values; rresp=00.
    - If araddr >= NUM_REGS: rdata=0, rresp=10.
  - R_RESP: arready=0, rvalid=1. Edge with rready=1 → rvalid=0, arready=1, go to R_IDLE.
  - Read latency: rvalid high the cycle after the AR handshake.
- Read and write channels are fully independent and may be active in the same cycle.
- Same-edge collision: a read handshake on the same edge as a write commit to the same register returns the OLD value. A read issued on a later edge sees the new value.
- Back-to-back operation: a new AW/W is accepted on the edge after the B handshake, and a new AR on the edge after the R handshake. Sustained throughput is 1 transaction per 2 cycles per direction.
- regs_flat reflects register state combinationally from the flops. It changes on the cycle after commit.
- Inputs to awaddr/araddr and all data inputs are don't-care when the corresponding valid is low.

Test Plan:
- Reset with rst=1 for 2 cycles, then release → awready=wready=arready=1, bvalid=rvalid=0, regs_flat=0.
- Simultaneous AW/W: awaddr=2, wdata=0x04, wstrb=1, bready=1 → bvalid 1 cycle later with bresp=00. Then araddr=2 → rvalid next cycle, rdata=0x04, rresp=00, regs_flat[23:16]=0x04.
- Split write:
  - W first (wdata=0xA5), awvalid withheld for 3 cycles → wready drops after the W handshake, awready stays 1, and no commit occurs.
  - Then awaddr=1 → reg1=0xA5 and bvalid follows 1 cycle later.
  - Reverse the order (AW first) → same result.
- Backpressure: hold bready=0 for 4 cycles after a write → bvalid and bresp stable, awready=wready=0, and a new AW is not accepted. Repeat with rready=0 on a read → rdata held stable.
- Out-of-range with NUM_REGS=3: write awaddr=3, wdata=0xFF → bresp=10, no register changes. Read araddr=3 → rresp=10, rdata=0.
- Collision: reg0=0x11. On the same edge, commit write reg0=0x22 and AR araddr=0 → rdata=0x11. A following read → 0x22.
- Reset asserted while bvalid=1 → bvalid=0, registers cleared, and no stale response issued.

Source files
------------

// File: rtl/axi4lite_slave_regs.sv
// axi4lite_slave_regs
//   AXI4-Lite responder holding NUM_REGS registers of DATA_WIDTH bits each.
//   AW and W may arrive together or in either order. The B and R responses
//   are held until accepted. Out-of-range addresses return SLVERR.
//
// Ports
//   clk, rst                     : clock, synchronous active-high reset
//   awaddr/awvalid/awready       : write address channel (word index)
//   wdata/wstrb/wvalid/wready    : write data channel with byte strobes
//   bresp/bvalid/bready          : write response channel
//   araddr/arvalid/arready       : read address channel (word index)
//   rdata/rresp/rvalid/rready    : read data channel
//   regs_flat                    : all registers, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
module axi4lite_slave_regs #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat
);

  localparam int STRB_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {W_IDLE, W_COLLECT, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_RESP} rstate_t;

  wstate_t w_state, w_next;
  rstate_t r_state, r_next;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // Half of a split write that has already handshaked
  logic                  have_aw, have_w;
  logic [ADDR_WIDTH-1:0] aw_lat;
  logic [DATA_WIDTH-1:0] w_data_lat;
  logic [STRB_W-1:0]     w_strb_lat;

  logic                  aw_hs, w_hs, ar_hs;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [DATA_WIDTH-1:0] c_data;
  logic [STRB_W-1:0]     c_strb;
  logic [DATA_WIDTH-1:0] rd_val;

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return 32'(a) < 32'(NUM_REGS);
  endfunction

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign ar_hs = arvalid && arready;

  // Commit uses whichever half was latched earlier, the other half live
  assign c_addr = have_aw ? aw_lat : awaddr;
  assign c_data = have_w ? w_data_lat : wdata;
  assign c_strb = have_w ? w_strb_lat : wstrb;

  // Write FSM: next state, readys, bvalid and the commit strobe
  always_comb begin
    w_next  = w_state;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    commit  = 1'b0;
    case (w_state)
      W_IDLE: begin
        awready = 1'b1;
        wready  = 1'b1;
        if (awvalid && wvalid) begin
          commit = 1'b1;
          w_next = W_RESP;
        end else if (awvalid || wvalid) begin
          w_next = W_COLLECT;
        end
      end
      W_COLLECT: begin
        awready = !have_aw;
        wready  = !have_w;
        if ((!have_aw && awvalid) || (!have_w && wvalid)) begin
          commit = 1'b1;
          w_next = W_RESP;
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      have_aw <= 1'b0;
      have_w  <= 1'b0;
      bresp   <= 2'b00;
    end else begin
      w_state <= w_next;
      if (commit) begin
        have_aw <= 1'b0;
        have_w  <= 1'b0;
        bresp   <= addr_ok(c_addr) ? 2'b00 : 2'b10;
      end else begin
        if (aw_hs) have_aw <= 1'b1;
        if (w_hs)  have_w  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (aw_hs) aw_lat <= awaddr;
    if (w_hs) begin
      w_data_lat <= wdata;
      w_strb_lat <= wstrb;
    end
  end

  // Register file: byte-lane writes on commit to an in-range address
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit && addr_ok(c_addr)) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (c_addr == ADDR_WIDTH'(i)) begin
          for (int k = 0; k < STRB_W; k++) begin
            if (c_strb[k]) regs[i][k*8 +: 8] <= c_data[k*8 +: 8];
          end
        end
      end
    end
  end

  // Read mux on pre-edge register values, so a same-edge write is not seen
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (araddr == ADDR_WIDTH'(i)) rd_val = regs[i];
    end
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (arvalid) r_next = R_RESP;
      R_RESP:  if (rready)  r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  assign arready = (r_state == R_IDLE);
  assign rvalid  = (r_state == R_RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      rdata   <= '0;
      rresp   <= 2'b00;
    end else begin
      r_state <= r_next;
      if (ar_hs) begin
        rdata <= addr_ok(araddr) ? rd_val : '0;
        rresp <= addr_ok(araddr) ? 2'b00 : 2'b10;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

endmodule

// File: tb/tb_axi4lite_slave_regs.sv
// Directed bench for axi4lite_slave_regs with NUM_REGS=3, 8-bit data.
module tb_axi4lite_slave_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [7:0]  wdata;
  logic [0:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [1:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [7:0]  rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [23:0] regs_flat;

  int n_checks = 0;
  int n_fail   = 0;

  axi4lite_slave_regs #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .NUM_REGS(3)) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .regs_flat(regs_flat)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = 1'b0; wvalid = 1'b0;
    bready = 1'b1; araddr = '0; arvalid = 1'b0; rready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_awready", awready, 1);
    chk("rst_wready", wready, 1);
    chk("rst_arready", arready, 1);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_regs", regs_flat, 0);
    chk("rst_rdata", rdata, 0);

    // Simultaneous AW/W to reg2
    awaddr = 2; awvalid = 1; wdata = 8'h04; wstrb = 1; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0;
    chk("sim_bvalid", bvalid, 1);
    chk("sim_bresp", bresp, 0);
    chk("sim_awready_busy", awready, 0);
    chk("sim_reg2", regs_flat[23:16], 8'h04);
    tick();
    chk("sim_bvalid_done", bvalid, 0);
    chk("sim_awready_back", awready, 1);
    araddr = 2; arvalid = 1;
    tick();
    arvalid = 0;
    chk("rd2_rvalid", rvalid, 1);
    chk("rd2_rdata", rdata, 8'h04);
    chk("rd2_rresp", rresp, 0);
    chk("rd2_arready", arready, 0);
    tick();
    chk("rd2_rvalid_done", rvalid, 0);

    // Split write, W first, AW withheld 3 cycles
    wdata = 8'hA5; wstrb = 1; wvalid = 1;
    tick();
    wvalid = 0; wdata = 8'h00;
    chk("wfirst_wready", wready, 0);
    chk("wfirst_awready", awready, 1);
    chk("wfirst_bvalid", bvalid, 0);
    tick(); tick();
    chk("wfirst_nocommit", regs_flat[15:8], 8'h00);
    chk("wfirst_bvalid_wait", bvalid, 0);
    awaddr = 1; awvalid = 1;
    tick();
    awvalid = 0;
    chk("wfirst_bvalid_now", bvalid, 1);
    chk("wfirst_reg1", regs_flat[15:8], 8'hA5);
    tick();

    // Split write, AW first
    awaddr = 0; awvalid = 1;
    tick();
    awvalid = 0; awaddr = 3;
    chk("awfirst_awready", awready, 0);
    chk("awfirst_wready", wready, 1);
    tick();
    chk("awfirst_nocommit", regs_flat[7:0], 8'h00);
    wdata = 8'h5A; wstrb = 1; wvalid = 1;
    tick();
    wvalid = 0;
    chk("awfirst_bvalid", bvalid, 1);
    chk("awfirst_reg0", regs_flat[7:0], 8'h5A);
    tick();

    // Write response backpressure
    bready = 0;
    awaddr = 1; wdata = 8'h3C; wstrb = 1; awvalid = 1; wvalid = 1;
    tick();
    awaddr = 0; wdata = 8'h77;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_bvalid", bvalid, 1);
      chk("bp_bresp", bresp, 0);
      chk("bp_awready", awready, 0);
      chk("bp_wready", wready, 0);
    end
    awvalid = 0; wvalid = 0; bready = 1;
    chk("bp_reg0_kept", regs_flat[7:0], 8'h5A);
    tick();
    chk("bp_bvalid_done", bvalid, 0);
    chk("bp_regs", regs_flat, 24'h043C5A);

    // Read response backpressure
    rready = 0;
    araddr = 1; arvalid = 1;
    tick();
    araddr = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rbp_rvalid", rvalid, 1);
      chk("rbp_rdata", rdata, 8'h3C);
      chk("rbp_arready", arready, 0);
    end
    arvalid = 0; rready = 1;
    tick();
    chk("rbp_rvalid_done", rvalid, 0);

    // Out-of-range write and read
    awaddr = 3; wdata = 8'hFF; wstrb = 1; awvalid = 1; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0;
    chk("oor_bvalid", bvalid, 1);
    chk("oor_bresp", bresp, 2'b10);
    chk("oor_regs", regs_flat, 24'h043C5A);
    tick();
    araddr = 3; arvalid = 1;
    tick();
    arvalid = 0;
    chk("oor_rresp", rresp, 2'b10);
    chk("oor_rdata", rdata, 0);
    tick();

    // Strobe low: in-range write with no lanes enabled
    awaddr = 0; wdata = 8'hFF; wstrb = 0; awvalid = 1; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0;
    chk("strb0_bresp", bresp, 0);
    chk("strb0_regs", regs_flat, 24'h043C5A);
    tick();

    // Collision: reg0=0x11, then write 0x22 and read reg0 on the same edge
    awaddr = 0; wdata = 8'h11; wstrb = 1; awvalid = 1; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0;
    tick();
    awaddr = 0; wdata = 8'h22; wstrb = 1; awvalid = 1; wvalid = 1;
    araddr = 0; arvalid = 1;
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    chk("coll_rdata_old", rdata, 8'h11);
    chk("coll_reg0_new", regs_flat[7:0], 8'h22);
    tick();
    arvalid = 1;
    tick();
    arvalid = 0;
    chk("coll_rdata_new", rdata, 8'h22);
    tick();

    // Reset while a write response is pending
    bready = 0;
    awaddr = 2; wdata = 8'h99; wstrb = 1; awvalid = 1; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0;
    chk("rstmid_bvalid_pre", bvalid, 1);
    rst = 1;
    tick();
    rst = 0;
    chk("rstmid_bvalid", bvalid, 0);
    chk("rstmid_regs", regs_flat, 0);
    chk("rstmid_awready", awready, 1);
    bready = 1;
    tick();
    chk("rstmid_no_stale", bvalid, 0);
    tick();
    chk("rstmid_no_stale2", bvalid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
